// File: rtl/pc_word_arbiter.sv
// pc_word_arbiter: three-input round-robin word arbiter with a one-word output slice.
// Codes 13 and 14 open a two-word packet.
// The input owning the lock keeps exclusive access until its second word moves, or until
// the stall timeout abandons the packet and sets a sticky error flag.
// Handshake: a word moves on any channel at a rising clk edge where valid and accept are
// both 1. Accepts are computed from valids, arbiter state and output-slice occupancy only,
// never from data. A source holds its word stable until it is accepted.
module pc_word_arbiter #(
    parameter  int NPCcode     = 8,
    parameter  int NPCdata     = 24,
    parameter  int NPCroute    = 11,
    parameter  int TIMEOUT_CYC = 1024,
    localparam int W           = NPCroute + NPCcode + NPCdata
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] in0_d,
    input  logic [W-1:0] in1_d,
    input  logic [W-1:0] in2_d,
    input  logic         in0_v,
    input  logic         in1_v,
    input  logic         in2_v,
    output logic         in0_a,
    output logic         in1_a,
    output logic         in2_a,
    output logic [W-1:0] out_d,
    output logic         out_v,
    input  logic         out_a,
    output logic         err_timeout,
    output logic [1:0]   grant_idx
);

    localparam int CW = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [CW-1:0] STALL_LIMIT = CW'(TIMEOUT_CYC - 1);

    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    // Registered state.
    state_t        state_q, state_d;
    logic [1:0]    ptr_q, ptr_d;
    logic [1:0]    grant_q, grant_d;
    logic [CW-1:0] stall_q, stall_d;
    logic          err_q, err_d;
    logic          out_v_q, out_v_d;
    logic [W-1:0]  out_d_q, out_d_d;

    // Combinational datapath.
    logic [1:0]         sel;
    logic [1:0]         cand1;
    logic [1:0]         cand2;
    logic [W-1:0]       sel_word;
    logic [NPCcode-1:0] sel_code;
    logic               sel_is_pair;
    logic               load_ok;
    logic               xfer;

    // Round-robin successor over the three inputs.
    function automatic logic [1:0] wrap_inc(input logic [1:0] x);
        return (x == 2'd2) ? 2'd0 : x + 2'd1;
    endfunction

    // Valid bit of input idx.
    function automatic logic valid_of(input logic [1:0] idx, input logic v0,
                                      input logic v1, input logic v2);
        logic v;
        case (idx)
            2'd0:    v = v0;
            2'd1:    v = v1;
            default: v = v2;
        endcase
        return v;
    endfunction

    // The slice can take a word when it is empty or is being drained this cycle.
    assign load_ok = !out_v_q || out_a;

    assign cand1 = wrap_inc(ptr_q);
    assign cand2 = wrap_inc(cand1);

    // Pick the input that may move this cycle: the lock owner, else first valid from ptr.
    always_comb begin
        sel = ptr_q;
        if (state_q == ST_LOCK) begin
            sel = grant_q;
        end else if (valid_of(ptr_q, in0_v, in1_v, in2_v)) begin
            sel = ptr_q;
        end else if (valid_of(cand1, in0_v, in1_v, in2_v)) begin
            sel = cand1;
        end else if (valid_of(cand2, in0_v, in1_v, in2_v)) begin
            sel = cand2;
        end
    end

    // Route the selected input's word to the slice input.
    always_comb begin
        sel_word = in2_d;
        case (sel)
            2'd0:    sel_word = in0_d;
            2'd1:    sel_word = in1_d;
            default: sel_word = in2_d;
        endcase
    end

    assign sel_code    = sel_word[NPCdata +: NPCcode];
    assign sel_is_pair = (sel_code == NPCcode'(13)) || (sel_code == NPCcode'(14));

    // Accepts are forced low while reset is asserted so nothing can move during reset.
    assign in0_a = !reset && load_ok && in0_v && (sel == 2'd0);
    assign in1_a = !reset && load_ok && in1_v && (sel == 2'd1);
    assign in2_a = !reset && load_ok && in2_v && (sel == 2'd2);
    assign xfer  = in0_a || in1_a || in2_a;

    // Arbitration FSM: lock on a packet's first word, release on its second or on timeout.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        stall_d = stall_q;
        err_d   = err_q;
        case (state_q)
            ST_ARB: begin
                if (xfer) begin
                    if (sel_is_pair) begin
                        state_d = ST_LOCK;
                        grant_d = sel;
                        stall_d = '0;
                    end else begin
                        ptr_d = wrap_inc(sel);
                    end
                end
            end
            ST_LOCK: begin
                if (xfer) begin
                    state_d = ST_ARB;
                    ptr_d   = wrap_inc(grant_q);
                    stall_d = '0;
                end else if (stall_q == STALL_LIMIT) begin
                    state_d = ST_ARB;
                    ptr_d   = wrap_inc(grant_q);
                    stall_d = '0;
                    err_d   = 1'b1;
                end else begin
                    stall_d = stall_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_ARB;
            end
        endcase
    end

    // Output slice: load the accepted word, or empty out when drained with nothing new.
    always_comb begin
        out_v_d = out_v_q;
        out_d_d = out_d_q;
        if (load_ok) begin
            out_v_d = xfer;
            if (xfer) begin
                out_d_d = sel_word;
            end
        end
    end

    // State registers; reset abandons any lock and discards the slice contents.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_ARB;
            ptr_q   <= 2'd0;
            grant_q <= 2'd0;
            stall_q <= '0;
            err_q   <= 1'b0;
            out_v_q <= 1'b0;
            out_d_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            stall_q <= stall_d;
            err_q   <= err_d;
            out_v_q <= out_v_d;
            out_d_q <= out_d_d;
        end
    end

    assign out_v       = out_v_q;
    assign out_d       = out_d_q;
    assign err_timeout = err_q;
    assign grant_idx   = grant_q;

endmodule

// File: tb/tb_pc_word_arbiter.sv
// Bench for pc_word_arbiter: directed scenarios plus a randomized run against a
// behavioural model of the arbitration rules and an expected-word queue.
module tb_pc_word_arbiter;
    localparam int NC = 8;
    localparam int ND = 24;
    localparam int NR = 11;
    localparam int W  = NR + NC + ND;
    localparam int T  = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [W-1:0]  d_in [3];
    logic [2:0]    v_in;
    logic          in0_a, in1_a, in2_a;
    logic [W-1:0]  out_d;
    logic          out_v;
    logic          out_a;
    logic          err_timeout;
    logic [1:0]    grant_idx;

    pc_word_arbiter #(.NPCcode(NC), .NPCdata(ND), .NPCroute(NR), .TIMEOUT_CYC(T)) dut (
        .clk(clk), .reset(reset),
        .in0_d(d_in[0]), .in1_d(d_in[1]), .in2_d(d_in[2]),
        .in0_v(v_in[0]), .in1_v(v_in[1]), .in2_v(v_in[2]),
        .in0_a(in0_a), .in1_a(in1_a), .in2_a(in2_a),
        .out_d(out_d), .out_v(out_v), .out_a(out_a),
        .err_timeout(err_timeout), .grant_idx(grant_idx)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Behavioural model state.
    bit           m_locked;
    int           m_owner, m_ptr, m_wait;
    bit           m_err, m_out_v;
    logic [W-1:0] m_out_d;
    logic [W-1:0] exp_q[$];

    // Per-cycle observations published by tick().
    logic [2:0]   obs_acc, exp_acc;
    int           last_pick;
    bit           hs, hs_empty;
    logic [W-1:0] hs_got, hs_exp;

    function automatic logic [W-1:0] mkw(input int code);
        logic [NR-1:0] r;
        logic [ND-1:0] p;
        r = NR'($urandom);
        p = ND'($urandom);
        return {r, NC'(code), p};
    endfunction

    function automatic int rnd_code();
        case ($urandom_range(0, 3))
            0:       return 13;
            1:       return 14;
            default: return int'($urandom_range(0, 255));
        endcase
    endfunction

    function automatic bit is_pair(input logic [W-1:0] w);
        int code;
        code = int'(w[ND +: NC]);
        return (code == 13) || (code == 14);
    endfunction

    function automatic int acc_idx(input logic [2:0] a);
        case (a)
            3'b000:  return -1;
            3'b001:  return 0;
            3'b010:  return 1;
            3'b100:  return 2;
            default: return -2;
        endcase
    endfunction

    // Which input the rules allow to move this cycle (-1: none).
    function automatic int model_pick();
        if (m_out_v && !out_a) return -1;
        if (m_locked) return v_in[m_owner] ? m_owner : -1;
        for (int k = 0; k < 3; k++) begin
            if (v_in[(m_ptr + k) % 3]) return (m_ptr + k) % 3;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_locked = 0; m_owner = 0; m_ptr = 0; m_wait = 0;
        m_err = 0; m_out_v = 0; m_out_d = '0;
        exp_q.delete();
    endtask

    // ---------------- driver tasks ----------------
    // One clock cycle: observe accepts before the edge, advance the model, land at posedge+1.
    task automatic tick();
        @(negedge clk);
        hs_empty  = 0;
        obs_acc   = {in2_a, in1_a, in0_a};
        last_pick = model_pick();
        exp_acc   = (last_pick >= 0) ? 3'(1 << last_pick) : 3'b000;
        hs        = out_v && out_a;
        hs_got    = out_d;
        if (hs) begin
            if (exp_q.size() == 0) hs_empty = 1;
            else hs_exp = exp_q.pop_front();
        end
        if (last_pick >= 0) exp_q.push_back(d_in[last_pick]);
        if (!m_out_v || out_a) begin
            m_out_v = (last_pick >= 0);
            if (last_pick >= 0) m_out_d = d_in[last_pick];
        end
        if (!m_locked) begin
            if (last_pick >= 0) begin
                if (is_pair(d_in[last_pick])) begin
                    m_locked = 1; m_owner = last_pick; m_wait = 0;
                end else begin
                    m_ptr = (last_pick + 1) % 3;
                end
            end
        end else if (last_pick >= 0) begin
            m_locked = 0; m_ptr = (m_owner + 1) % 3;
        end else begin
            m_wait++;
            if (m_wait == T) begin
                m_err = 1; m_locked = 0; m_ptr = (m_owner + 1) % 3;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic release_reset();
        v_in = 3'b000;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic fresh();
        reset = 1'b1;
        #2;
        release_reset();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        out_a = 1'b1;
        for (int i = 0; i < 3; i++) d_in[i] = mkw(0);
        v_in = 3'b111;
        #2;
        n_total++; if (out_v !== 1'b0) $display("FAIL reset_out_v: got %b want 0", out_v); else n_pass++;
        n_total++; if (out_d !== '0) $display("FAIL reset_out_d: got %h want 0", out_d); else n_pass++;
        n_total++; if ({in2_a, in1_a, in0_a} !== 3'b000) $display("FAIL reset_accepts: got %b want 000", {in2_a, in1_a, in0_a}); else n_pass++;
        n_total++; if (err_timeout !== 1'b0) $display("FAIL reset_err: got %b want 0", err_timeout); else n_pass++;
        n_total++; if (grant_idx !== 2'd0) $display("FAIL reset_grant: got %0d want 0", grant_idx); else n_pass++;
        release_reset();
    endtask

    task automatic test_round_robin();
        int seq[$];
        int idx;
        fresh();
        out_a = 1'b1;
        for (int i = 0; i < 3; i++) d_in[i] = mkw(0);
        v_in = 3'b111;
        for (int c = 0; c < 9; c++) begin
            tick();
            n_total++; if (obs_acc !== exp_acc) $display("FAIL rr_accept c%0d: got %b want %b", c, obs_acc, exp_acc); else n_pass++;
            n_total++; if (out_v !== m_out_v) $display("FAIL rr_out_v c%0d: got %b want %b", c, out_v, m_out_v); else n_pass++;
            if (m_out_v) begin
                n_total++; if (out_d !== m_out_d) $display("FAIL rr_out_d c%0d: got %h want %h", c, out_d, m_out_d); else n_pass++;
            end
            idx = acc_idx(obs_acc);
            if (idx >= 0) begin
                seq.push_back(idx);
                d_in[idx] = mkw(0);
            end
        end
        n_total++; if (seq.size() != 9) $display("FAIL rr_count: got %0d want 9", seq.size()); else n_pass++;
        for (int k = 0; k < seq.size(); k++) begin
            n_total++; if (seq[k] != k % 3) $display("FAIL rr_order k%0d: got in%0d want in%0d", k, seq[k], k % 3); else n_pass++;
        end
    endtask

    task automatic test_lock();
        int seq[$];
        logic [W-1:0] outs[$];
        logic [W-1:0] wa, wb;
        int idx, stage, gap, pa;
        fresh();
        out_a = 1'b1;
        d_in[0] = mkw(0); d_in[2] = mkw(0);
        wa = mkw(13); wb = mkw(13);
        d_in[1] = wa;
        v_in = 3'b111;
        stage = 0; gap = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            n_total++; if (obs_acc !== exp_acc) $display("FAIL lock_accept c%0d: got %b want %b", c, obs_acc, exp_acc); else n_pass++;
            if (m_out_v) begin
                n_total++; if (out_d !== m_out_d) $display("FAIL lock_out_d c%0d: got %h want %h", c, out_d, m_out_d); else n_pass++;
            end
            if (out_v) outs.push_back(out_d);
            idx = acc_idx(obs_acc);
            if (idx >= 0) seq.push_back(idx);
            if (idx == 0 || idx == 2) d_in[idx] = mkw(0);
            if (idx == 1 && stage == 0) begin
                stage = 1; v_in[1] = 1'b0;
            end else if (idx == 1 && stage == 2) begin
                stage = 3; v_in[1] = 1'b0;
            end
            if (stage == 1) begin
                gap++;
                if (gap == 3) begin
                    stage = 2; d_in[1] = wb; v_in[1] = 1'b1;
                end
            end
        end
        n_total++; if (seq.size() < 4) $display("FAIL lock_seq_len: got %0d want >=4", seq.size()); else n_pass++;
        if (seq.size() >= 4) begin
            n_total++; if (seq[0] != 0 || seq[1] != 1 || seq[2] != 1 || seq[3] != 2)
                $display("FAIL lock_seq: got %0d,%0d,%0d,%0d want 0,1,1,2", seq[0], seq[1], seq[2], seq[3]);
            else n_pass++;
        end
        pa = -1;
        for (int k = 0; k < outs.size(); k++) if (outs[k] === wa && pa < 0) pa = k;
        n_total++; if (pa < 0 || pa + 1 >= outs.size() || outs[pa + 1] !== wb)
            $display("FAIL lock_contiguous: A at %0d of %0d, B not next (want B=%h)", pa, outs.size(), wb);
        else n_pass++;
    endtask

    task automatic test_timeout();
        int rise_at, first_after, idx;
        fresh();
        out_a = 1'b1;
        d_in[1] = mkw(14);
        v_in = 3'b010;
        tick();
        n_total++; if (obs_acc !== 3'b010) $display("FAIL to_first_accept: got %b want 010", obs_acc); else n_pass++;
        n_total++; if (grant_idx !== 2'd1) $display("FAIL to_grant: got %0d want 1", grant_idx); else n_pass++;
        v_in = 3'b101;
        d_in[0] = mkw(0); d_in[2] = mkw(0);
        rise_at = -1; first_after = -1;
        for (int k = 1; k <= 14; k++) begin
            tick();
            n_total++; if (obs_acc !== exp_acc) $display("FAIL to_accept k%0d: got %b want %b", k, obs_acc, exp_acc); else n_pass++;
            n_total++; if (err_timeout !== m_err) $display("FAIL to_err k%0d: got %b want %b", k, err_timeout, m_err); else n_pass++;
            if (err_timeout === 1'b1 && rise_at < 0) rise_at = k;
            idx = acc_idx(obs_acc);
            if (idx >= 0) begin
                if (first_after < 0) first_after = idx;
                d_in[idx] = mkw(0);
            end
        end
        n_total++; if (rise_at != 8) $display("FAIL to_rise_cycle: got %0d want 8", rise_at); else n_pass++;
        n_total++; if (first_after != 2) $display("FAIL to_next_grant: got in%0d want in2", first_after); else n_pass++;
        n_total++; if (err_timeout !== 1'b1) $display("FAIL to_sticky: got %b want 1", err_timeout); else n_pass++;
    endtask

    task automatic test_threshold();
        logic [W-1:0] wb;
        fresh();
        out_a = 1'b1;
        d_in[1] = mkw(13);
        v_in = 3'b010;
        tick();
        v_in = 3'b000;
        for (int k = 1; k <= 7; k++) begin
            tick();
            n_total++; if (obs_acc !== 3'b000) $display("FAIL th_idle k%0d: got %b want 000", k, obs_acc); else n_pass++;
            n_total++; if (err_timeout !== 1'b0) $display("FAIL th_err_idle k%0d: got %b want 0", k, err_timeout); else n_pass++;
        end
        wb = mkw(0);
        d_in[1] = wb;
        v_in = 3'b010;
        tick();
        n_total++; if (obs_acc !== 3'b010) $display("FAIL th_second_accept: got %b want 010", obs_acc); else n_pass++;
        n_total++; if (out_v !== 1'b1 || out_d !== wb) $display("FAIL th_second_out: got v=%b d=%h want v=1 d=%h", out_v, out_d, wb); else n_pass++;
        v_in = 3'b000;
        repeat (3) tick();
        n_total++; if (err_timeout !== 1'b0) $display("FAIL th_err_after: got %b want 0", err_timeout); else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [W-1:0] held;
        int idx;
        fresh();
        out_a = 1'b1;
        for (int i = 0; i < 3; i++) d_in[i] = mkw(0);
        v_in = 3'b111;
        for (int c = 0; c < 13; c++) begin
            out_a = !(c >= 2 && c < 7);
            if (c == 2) held = out_d;
            tick();
            n_total++; if (obs_acc !== exp_acc) $display("FAIL bp_accept c%0d: got %b want %b", c, obs_acc, exp_acc); else n_pass++;
            if (c >= 2 && c < 7) begin
                n_total++; if (obs_acc !== 3'b000 || out_d !== held)
                    $display("FAIL bp_stall c%0d: got acc=%b d=%h want acc=000 d=%h", c, obs_acc, out_d, held);
                else n_pass++;
            end
            if (hs) begin
                n_total++; if (hs_empty || hs_got !== hs_exp) $display("FAIL bp_order c%0d: got %h want %h", c, hs_got, hs_exp); else n_pass++;
            end
            idx = acc_idx(obs_acc);
            if (idx >= 0) d_in[idx] = mkw(0);
        end
    endtask

    task automatic test_reset_mid_lock();
        fresh();
        out_a = 1'b1;
        d_in[1] = mkw(13);
        v_in = 3'b010;
        tick();
        out_a = 1'b0;
        for (int i = 0; i < 3; i++) d_in[i] = mkw(0);
        v_in = 3'b111;
        #2;
        reset = 1'b1;
        #1;
        n_total++; if (out_v !== 1'b0) $display("FAIL rml_out_v: got %b want 0", out_v); else n_pass++;
        n_total++; if ({in2_a, in1_a, in0_a} !== 3'b000) $display("FAIL rml_accepts: got %b want 000", {in2_a, in1_a, in0_a}); else n_pass++;
        release_reset();
        out_a = 1'b1;
        v_in = 3'b111;
        tick();
        n_total++; if (obs_acc !== 3'b001) $display("FAIL rml_first_grant: got %b want 001", obs_acc); else n_pass++;
        n_total++; if (err_timeout !== 1'b0) $display("FAIL rml_err: got %b want 0", err_timeout); else n_pass++;
    endtask

    task automatic test_random();
        int idx, rate;
        fresh();
        for (int c = 0; c < 600; c++) begin
            rate  = ((c / 100) % 2 == 1) ? 60 : 12;
            out_a = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 3; i++) begin
                if (!v_in[i] && $urandom_range(0, 99) < rate) begin
                    d_in[i] = mkw(rnd_code());
                    v_in[i] = 1'b1;
                end
            end
            tick();
            n_total++; if (obs_acc !== exp_acc) $display("FAIL rnd_accept c%0d: got %b want %b", c, obs_acc, exp_acc); else n_pass++;
            n_total++; if (out_v !== m_out_v) $display("FAIL rnd_out_v c%0d: got %b want %b", c, out_v, m_out_v); else n_pass++;
            if (m_out_v) begin
                n_total++; if (out_d !== m_out_d) $display("FAIL rnd_out_d c%0d: got %h want %h", c, out_d, m_out_d); else n_pass++;
            end
            n_total++; if (err_timeout !== m_err) $display("FAIL rnd_err c%0d: got %b want %b", c, err_timeout, m_err); else n_pass++;
            if (m_locked) begin
                n_total++; if (grant_idx !== 2'(m_owner)) $display("FAIL rnd_grant c%0d: got %0d want %0d", c, grant_idx, m_owner); else n_pass++;
            end
            if (hs) begin
                n_total++; if (hs_empty || hs_got !== hs_exp) $display("FAIL rnd_order c%0d: got %h want %h", c, hs_got, hs_exp); else n_pass++;
            end
            idx = acc_idx(obs_acc);
            if (idx >= 0) v_in[idx] = 1'b0;
        end
    endtask

    // ---------------- sequence and final report ----------------
    initial begin
        reset = 1'b1;
        out_a = 1'b1;
        v_in  = 3'b000;
        for (int i = 0; i < 3; i++) d_in[i] = '0;
        model_reset();
        #12;
        test_reset();
        test_round_robin();
        test_lock();
        test_timeout();
        test_threshold();
        test_backpressure();
        test_reset_mid_lock();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pc_word_arbiter.md
PC_WORD_ARBITER -- requirements
Module: pc_word_arbiter

Interface
REQ-001 SHALL have parameter NPCcode, default 8: code field width.
REQ-002 SHALL have parameter NPCdata, default 24: payload field width.
REQ-003 SHALL have parameter NPCroute, default 11: route field width; word W = NPCroute+NPCcode+NPCdata (43), packed {route, code, payload}.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 1024: max stall cycles while waiting for the 2nd word of a packet.
REQ-005 SHALL have ports clk (in, 1, clock) and reset (in, 1, asynchronous active-high reset), listed first.
REQ-006 SHALL have ports in0_d/in1_d/in2_d (in, W; word from BD, FPGA and Global sources respectively).
REQ-007 SHALL have ports in0_v/in1_v/in2_v (in, 1; input valid) and in0_a/in1_a/in2_a (out, 1; input accept).
REQ-008 SHALL have ports out_d (out, W; granted word), out_v (out, 1; output valid) and out_a (in, 1; downstream accept).
REQ-009 SHALL have port err_timeout (out, 1; sticky flag, split packet abandoned).
REQ-010 SHALL have port grant_idx (out, 2; input currently owning the lock, valid while locked).

Function
REQ-011 Transfer on any channel SHALL occur on a rising clk edge where v=1 and a=1; a SHALL NOT depend combinationally on d.
REQ-012 Output SHALL be a one-word register slice: load_ok = !out_v | out_a; a load sets out_v=1 and out_d=selected word one cycle later; with out_a=1 and no load, out_v clears.
REQ-013 At most one inX_a SHALL be 1 per cycle; inX_a = (sel==X) & inX_v & load_ok.
REQ-014 FSM SHALL have two states: ARB (unlocked) and LOCK (mid-packet).
REQ-015 In ARB, sel SHALL be the first valid input scanning from rotating pointer ptr upward modulo 3 (ptr, ptr+1, ptr+2).
REQ-016 A word whose code field equals 13 or 14 SHALL be a 2-word packet; all other codes SHALL be 1-word packets.
REQ-017 ARB, transfer of a 1-word packet from input X -> stay ARB, ptr = (X+1) mod 3.
REQ-018 ARB, transfer of the 1st word of a 2-word packet from X -> LOCK with grant_idx = X, ptr unchanged, stall counter cleared.
REQ-019 In LOCK, sel SHALL be grant_idx only; other inputs SHALL see a=0 regardless of their valid.
REQ-020 In LOCK, the next transfer from grant_idx (any code) SHALL be the 2nd word -> ARB, ptr = (grant_idx+1) mod 3.
REQ-021 In LOCK, each cycle without a transfer SHALL increment a stall counter (clog2(TIMEOUT_CYC)+1 bits); stalls caused by load_ok=0 SHALL also count.
REQ-022 When the stall counter reaches TIMEOUT_CYC-1 and no transfer occurs that cycle, the block SHALL set err_timeout=1 and enter ARB with ptr = (grant_idx+1) mod 3.
REQ-023 A transfer in the same cycle as the timeout threshold SHALL take precedence (normal 2nd-word completion, no error).
REQ-024 err_timeout SHALL remain 1 until reset.
REQ-025 Throughput SHALL be one word per cycle when out_a is held high; input-to-output latency SHALL be exactly 1 cycle.
REQ-026 No word SHALL be dropped or duplicated, and words from one input SHALL leave in arrival order.

Reset
REQ-027 On reset assertion (asynchronous), outputs SHALL immediately become out_v=0, out_d=0, inX_a=0, err_timeout=0, grant_idx=0; state SHALL be ARB, ptr=0, stall counter=0.
REQ-028 Reset asserted mid-packet SHALL abandon the lock without setting err_timeout; a word held in the output slice SHALL be discarded.
REQ-029 After deassertion, the first grant SHALL follow REQ-015 with ptr=0.

Verification
REQ-030 All three inputs valid with code 0, out_a=1 -> out_d sources in0, in1, in2, in0... one word per cycle, first out_v the cycle after the first accept.
REQ-031 in1 sends code 13 words A then B (B valid 3 cycles later), in0/in2 continuously valid -> out sequence A, B contiguous with no in0/in2 words between; then in2 granted next.
REQ-032 in1 sends code 14 first word then drops valid, TIMEOUT_CYC=8 -> err_timeout rises 8 cycles after the accept; in2 is granted next; flag stays 1.
REQ-033 out_a=0 for 5 cycles with all inputs valid -> out_d stable, all inX_a=0 after the slice fills; on out_a=1, round-robin resumes with no loss.
REQ-034 Reset asserted while in LOCK with out_v=1 -> out_v=0 and all inX_a=0 immediately; after release in0 is granted first and err_timeout=0.
REQ-035 2nd word arrives on exactly the timeout-threshold cycle -> packet completes normally, err_timeout stays 0.
